// File: rtl/regfile_port_scheduler_if.sv
// rtl/regfile_port_scheduler_if.sv - Bundle of WB, long-latency, decode and regfile port signals (RF_BYPASS_EN adds forwarding).
interface regfile_port_scheduler_if;
    logic        wb_we;
    logic [4:0]  wb_rw;
    logic [31:0] wb_w;
    logic        wb_stall;
    logic        lu_issue;
    logic [4:0]  lu_issue_rw;
    logic        lu_valid;
    logic [4:0]  lu_rw;
    logic [31:0] lu_w;
    logic        lu_ready;
    logic [4:0]  id_ra;
    logic [4:0]  id_rb;
    logic [4:0]  id_rw;
    logic        hazard;
    logic [31:0] busy_vec;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_w;
`ifdef RF_BYPASS_EN
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
`endif

    modport master (
        output wb_we, wb_rw, wb_w, lu_issue, lu_issue_rw, lu_valid, lu_rw, lu_w,
        output id_ra, id_rb, id_rw,
`ifdef RF_BYPASS_EN
        output rf_a, rf_b,
        input  fwd_a, fwd_b,
`endif
        input  wb_stall, lu_ready, hazard, busy_vec, rf_we, rf_rw, rf_w
    );

    modport slave (
        input  wb_we, wb_rw, wb_w, lu_issue, lu_issue_rw, lu_valid, lu_rw, lu_w,
        input  id_ra, id_rb, id_rw,
`ifdef RF_BYPASS_EN
        input  rf_a, rf_b,
        output fwd_a, fwd_b,
`endif
        output wb_stall, lu_ready, hazard, busy_vec, rf_we, rf_rw, rf_w
    );
endinterface

// File: rtl/regfile_port_scheduler.sv
// rtl/regfile_port_scheduler.sv - Register file write-port arbiter with busy scoreboard; RF_BYPASS_EN adds decode forwarding.
module regfile_port_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_port_scheduler_if.slave  bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [31:0]      busy;
    logic [CNT_W-1:0] starve_cnt;
    logic             stall_q;

    logic        lu_ready;
    logic        lu_grant;
    logic        wb_grant;
    logic [4:0]  sel_rw;
    logic [31:0] sel_w;
    logic        hz_a;
    logic        hz_b;

    // A forced stall cycle hands the port to the long-latency unit regardless of WB.
    assign wb_grant = bus.wb_we & ~stall_q;
    assign lu_ready = ~wb_grant;
    assign lu_grant = bus.lu_valid & lu_ready;

    always_comb begin
        sel_rw = bus.lu_rw;
        sel_w  = bus.lu_w;
        if (wb_grant) begin
            sel_rw = bus.wb_rw;
            sel_w  = bus.wb_w;
        end
    end

    assign bus.rf_we    = (wb_grant | lu_grant) & (sel_rw != 5'd0);
    assign bus.rf_rw    = sel_rw;
    assign bus.rf_w     = sel_w;
    assign bus.lu_ready = lu_ready;
    assign bus.wb_stall = stall_q;
    assign bus.busy_vec = busy;

`ifdef RF_BYPASS_EN
    assign bus.fwd_a = (bus.rf_we && bus.rf_rw == bus.id_ra && bus.id_ra != 5'd0) ? bus.rf_w : bus.rf_a;
    assign bus.fwd_b = (bus.rf_we && bus.rf_rw == bus.id_rb && bus.id_rb != 5'd0) ? bus.rf_w : bus.rf_b;
    // A source being written this cycle is forwarded, so its busy bit no longer blocks decode.
    assign hz_a = busy[bus.id_ra] & ~(lu_grant && bus.lu_rw == bus.id_ra);
    assign hz_b = busy[bus.id_rb] & ~(lu_grant && bus.lu_rw == bus.id_rb);
`else
    assign hz_a = busy[bus.id_ra];
    assign hz_b = busy[bus.id_rb];
`endif

    assign bus.hazard = hz_a | hz_b | busy[bus.id_rw];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 32'd0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (!bus.lu_valid || lu_grant) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            stall_q <= (starve_cnt == LIMIT) && !stall_q;

            // Later assignment wins: a new issue supersedes a same-cycle completion.
            if (lu_grant) begin
                busy[bus.lu_rw] <= 1'b0;
            end
            if (bus.lu_issue && bus.lu_issue_rw != 5'd0) begin
                busy[bus.lu_issue_rw] <= 1'b1;
            end
        end
    end
endmodule
